// File: rtl/pipe_branch_pred_if.sv
// pipe_branch_pred_if: lookup, update and stats signals between the IF/EX stages and the branch predictor
interface pipe_branch_pred_if #(parameter int PC_W = 32);
  logic [PC_W-1:0] if_pc_i;
  logic            pred_hit_o;
  logic            pred_taken_o;
  logic [PC_W-1:0] pred_target_o;
  logic            upd_valid_i;
  logic [PC_W-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [PC_W-1:0] upd_target_i;
  logic            upd_pred_taken_i;
  logic [PC_W-1:0] upd_pred_target_i;
  logic            inv_all_i;
  logic            mispred_o;
  logic [31:0]     upd_cnt_o;
  logic [31:0]     mispred_cnt_o;
  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, inv_all_i,
    output pred_hit_o, pred_taken_o, pred_target_o, mispred_o, upd_cnt_o, mispred_cnt_o
  );
  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i, inv_all_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, mispred_o, upd_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/pipe_branch_pred.sv
// pipe_branch_pred: direct-mapped BTB with saturating direction counters, combinational lookup.
// Define BP_STATS_EN to build the update/misprediction statistics counters.
module pipe_branch_pred #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_branch_pred_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_WT  = cnt_t'(1 << (CNT_W - 1));
  localparam cnt_t CNT_WNT = cnt_t'((1 << (CNT_W - 1)) - 1);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  cnt_t               r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_idx, w_uidx;
  logic [TAG_W-1:0] w_tag, w_utag;
  logic             w_hit, w_taken, w_uhit, w_accept, w_unused;
  cnt_t             w_ucnt, w_cnt_next;

  assign w_idx   = bp.if_pc_i[IDX_W+1:2];
  assign w_tag   = bp.if_pc_i[PC_W-1:IDX_W+2];
  assign w_uidx  = bp.upd_pc_i[IDX_W+1:2];
  assign w_utag  = bp.upd_pc_i[PC_W-1:IDX_W+2];
  assign w_unused = ^{bp.if_pc_i[1:0], bp.upd_pc_i[1:0]};

  assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_taken = w_hit && r_cnt[w_idx][CNT_W-1];
  assign bp.pred_hit_o    = w_hit;
  assign bp.pred_taken_o  = w_taken;
  assign bp.pred_target_o = w_taken ? r_target[w_idx] : bp.if_pc_i + PC_W'(4);

  assign bp.mispred_o = bp.upd_valid_i &&
                        ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
                         (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i)));

  assign w_accept   = bp.upd_valid_i && !bp.inv_all_i;
  assign w_uhit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_ucnt     = r_cnt[w_uidx];
  assign w_cnt_next = bp.upd_taken_i ? ((w_ucnt == CNT_MAX) ? w_ucnt : w_ucnt + cnt_t'(1))
                                     : ((w_ucnt == '0) ? w_ucnt : w_ucnt - cnt_t'(1));

  // valid bits and counters carry reset state; tags and targets do not need it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_WNT;
    end else if (bp.inv_all_i) begin
      r_valid <= '0;
    end else if (bp.upd_valid_i) begin
      if (w_uhit) begin
        r_cnt[w_uidx] <= w_cnt_next;
      end else if (bp.upd_taken_i) begin
        r_valid[w_uidx] <= 1'b1;
        r_cnt[w_uidx]   <= CNT_WT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept && bp.upd_taken_i) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= bp.upd_target_i;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_upd_cnt, r_mis_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_upd_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (w_accept) begin
      r_upd_cnt <= r_upd_cnt + 32'd1;
      r_mis_cnt <= r_mis_cnt + {31'd0, bp.mispred_o};
    end
  end
  assign bp.upd_cnt_o     = r_upd_cnt;
  assign bp.mispred_cnt_o = r_mis_cnt;
`else
  assign bp.upd_cnt_o     = '0;
  assign bp.mispred_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_branch_pred.sv
// tb_pipe_branch_pred: directed plan steps then random traffic against a table-level reference model.
module tb_pipe_branch_pred;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_branch_pred_if #(.PC_W(32)) bp();
  pipe_branch_pred #(.ENTRIES(16), .PC_W(32), .CNT_W(2)) dut (.clk_i(clk), .rst_i(rst), .bp(bp));

  int checks = 0;
  int failures = 0;

  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic [31:0] m_upd, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_i(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_i(pc)] && (m_tag[m_i(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_i(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[m_i(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispred();
    return bp.upd_valid_i && ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
           (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i)));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i] = 1;
    end
    m_upd = 0;
    m_mis = 0;
  endtask

  task automatic m_clock();
    int i;
    i = m_i(bp.upd_pc_i);
    if (bp.upd_valid_i && !bp.inv_all_i) begin
      m_upd++;
      if (m_mispred()) m_mis++;
    end
    if (bp.inv_all_i) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (bp.upd_valid_i) begin
      if (m_hit(bp.upd_pc_i)) begin
        m_cnt[i] = bp.upd_taken_i ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                  : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (bp.upd_taken_i) m_tgt[i] = bp.upd_target_i;
      end else if (bp.upd_taken_i) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = bp.upd_pc_i >> 6;
        m_tgt[i]   = bp.upd_target_i;
        m_cnt[i]   = 2;
      end
    end
  endtask

  function automatic logic [31:0] exp_upd();
`ifdef BP_STATS_EN
    return m_upd;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mis();
`ifdef BP_STATS_EN
    return m_mis;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc(input string s);
    #1;
    chk({s, ".hit"},     32'(bp.pred_hit_o),   32'(m_hit(bp.if_pc_i)));
    chk({s, ".taken"},   32'(bp.pred_taken_o), 32'(m_taken(bp.if_pc_i)));
    chk({s, ".target"},  bp.pred_target_o,     m_target(bp.if_pc_i));
    chk({s, ".mispred"}, 32'(bp.mispred_o),    32'(m_mispred()));
    chk({s, ".updcnt"},  bp.upd_cnt_o,         exp_upd());
    chk({s, ".miscnt"},  bp.mispred_cnt_o,     exp_mis());
    @(posedge clk);
    m_clock();
    #4;
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg, input logic inv);
    bp.upd_valid_i = v;
    bp.upd_pc_i = pc;
    bp.upd_taken_i = t;
    bp.upd_target_i = tg;
    bp.upd_pred_taken_i = pt;
    bp.upd_pred_target_i = ptg;
    bp.inv_all_i = inv;
  endtask

  task automatic idle(input logic [31:0] pc);
    bp.if_pc_i = pc;
    upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] pc, tg;
    logic t;
    rst = 1'b1;
    idle(32'h40);
    m_reset();
    #12 rst = 1'b0;
    @(posedge clk);
    #4;
    #1 chk("reset.hit", 32'(bp.pred_hit_o), 32'd0);
    chk("reset.taken", 32'(bp.pred_taken_o), 32'd0);
    chk("reset.target", bp.pred_target_o, 32'h44);
    cyc("reset");
    idle(32'hFFFF_FFFC);
    #1 chk("wrap.target", bp.pred_target_o, 32'h0);
    cyc("wrap");

    bp.if_pc_i = 32'h40;
    upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
    cyc("alloc");
    idle(32'h40);
    #1 chk("alloc.hit", 32'(bp.pred_hit_o), 32'd1);
    chk("alloc.taken", 32'(bp.pred_taken_o), 32'd1);
    chk("alloc.target", bp.pred_target_o, 32'h100);
    cyc("alloc_look");
    idle(32'h80);
    #1 chk("alias.hit", 32'(bp.pred_hit_o), 32'd0);
    cyc("alias");

    bp.if_pc_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0);
      cyc("dec");
    end
    idle(32'h40);
    #1 chk("floor.hit", 32'(bp.pred_hit_o), 32'd1);
    chk("floor.taken", 32'(bp.pred_taken_o), 32'd0);
    cyc("floor");
    for (int i = 0; i < 4; i++) begin
      upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
      cyc("inc");
    end
    idle(32'h40);
    #1 chk("sat.taken", 32'(bp.pred_taken_o), 32'd1);
    cyc("sat");
    upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0);
    cyc("sat_dec");
    idle(32'h40);
    #1 chk("sat_dec.taken", 32'(bp.pred_taken_o), 32'd1);
    cyc("sat_dec_look");

    bp.if_pc_i = 32'h200;
    upd(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 1'b0);
    #1 chk("nobypass.hit", 32'(bp.pred_hit_o), 32'd0);
    cyc("nobypass");
    idle(32'h200);
    #1 chk("nobypass.next", 32'(bp.pred_hit_o), 32'd1);
    cyc("nobypass_next");

    bp.if_pc_i = 32'h40;
    upd(1'b1, 32'h40, 1'b1, 32'h500, 1'b1, 32'h100, 1'b1);
    cyc("inv");
    idle(32'h40);
    #1 chk("inv.hit", 32'(bp.pred_hit_o), 32'd0);
    cyc("inv_look");
    idle(32'h200);
    cyc("inv_look2");

    upd(1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h44, 1'b0);
    cyc("realloc");
    idle(32'h40);
    #1 chk("pre_rst.hit", 32'(bp.pred_hit_o), 32'd1);
    rst = 1'b1;
    #1 chk("async_rst.hit", 32'(bp.pred_hit_o), 32'd0);
    chk("async_rst.target", bp.pred_target_o, 32'h44);
    chk("async_rst.updcnt", bp.upd_cnt_o, 32'd0);
    chk("async_rst.miscnt", bp.mispred_cnt_o, 32'd0);
    m_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #4;
    cyc("post_rst");

    for (int i = 0; i < 5; i++) begin
      t = (i == 1 || i == 4);
      upd(1'b1, 32'h300 + 32'(i * 4), t, 32'h1000, 1'b0, 32'h304 + 32'(i * 4), 1'b0);
      cyc("stats");
    end
    idle(32'h40);
`ifdef BP_STATS_EN
    #1 chk("stats.upd", bp.upd_cnt_o, 32'd5);
    chk("stats.mis", bp.mispred_cnt_o, 32'd2);
`else
    #1 chk("stats.upd", bp.upd_cnt_o, 32'd0);
    chk("stats.mis", bp.mispred_cnt_o, 32'd0);
`endif
    cyc("stats_end");

    for (int n = 0; n < 600; n++) begin
      pc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) pc = pc | 32'hFFFF_FF00;
      bp.if_pc_i = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      t = 1'($urandom_range(0, 1));
      tg = $urandom_range(0, 7) << 4;
      if ($urandom_range(0, 1) == 1)
        upd(1'($urandom_range(0, 3) != 0), pc, t, tg, m_taken(pc), m_target(pc),
            1'($urandom_range(0, 31) == 0));
      else
        upd(1'($urandom_range(0, 3) != 0), pc, t, tg, 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) << 4, 1'($urandom_range(0, 31) == 0));
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_branch_pred.md
# pipe_branch_pred

Parametrised branch predictor with branch-target buffer, used by the pipelined CPU's IF stage to redirect fetch before branches resolve. It is a direct-mapped table of ENTRIES slots; each slot holds a tag, a target and a saturating direction counter. IF looks the table up combinationally each cycle, and EX writes one resolved-branch update per cycle.

## Interface
- ENTRIES, 16: table slots; power of two, 4..256; IDX_W = log2(ENTRIES).
- PC_W, 32: PC and target width.
- CNT_W, 2: direction-counter width, 1..4.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- if_pc_i  in  PC_W  fetch PC to predict.
- pred_hit_o  out  1  valid slot with matching tag.
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  PC_W  next fetch PC.
- upd_valid_i  in  1  resolved-branch update strobe.
- upd_pc_i  in  PC_W  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  PC_W  actual taken target.
- upd_pred_taken_i  in  1  direction predicted for this branch at fetch.
- upd_pred_target_i  in  PC_W  next-PC predicted for this branch at fetch.
- inv_all_i  in  1  invalidate the whole table.
- mispred_o  out  1  combinational: upd_valid_i and the prediction was wrong.
- upd_cnt_o  out  32  number of updates (stats).
- mispred_cnt_o  out  32  number of mispredictions (stats).

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2]. pc[1:0] is ignored.
- Lookup is combinational from if_pc_i and the registered table:
  - pred_hit_o = valid && tag match.
  - pred_taken_o = pred_hit_o && counter MSB.
  - pred_target_o = stored target when pred_taken_o, else if_pc_i + 4, with mod 2^PC_W wrap.
- mispred_o = upd_valid_i && (upd_pred_taken_i != upd_taken_i || (upd_taken_i && upd_pred_target_i != upd_target_i)).
- Update, on a clock edge with upd_valid_i = 1:
  - Hit: counter increments on taken and decrements on not-taken, saturating at 2^CNT_W-1 and at 0. The target is overwritten only when taken.
  - Miss and taken: allocate or replace the slot. Set valid, tag and target; counter = 2^(CNT_W-1), i.e. weakly taken.
  - Miss and not-taken: no table change.
- inv_all_i clears every valid bit at the clock edge and has priority over a same-cycle update, which is dropped. Counters and targets keep their values.
- Reset clears all valid bits and sets every counter to 2^(CNT_W-1)-1 (weakly not-taken). Targets and tags are don't-care.

## Timing
- Lookup has zero latency; the outputs are purely combinational from if_pc_i and the table state.
- An update becomes visible to lookups in the cycle after its edge.
- Same-cycle lookup and update to the same slot: the lookup returns the pre-update contents. There is no bypass.
- One update per cycle; back-to-back updates to the same slot accumulate, e.g. two taken updates from counter 1 reach 3.
- Reset asserted mid-operation immediately forces the outputs to their reset values: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = if_pc_i + 4, and both counters = 0. mispred_o stays combinational.

## Configuration
- Macro: BP_STATS_EN.
- Defined:
  - upd_cnt_o increments on every accepted update (upd_valid_i && !inv_all_i).
  - mispred_cnt_o increments when that accepted update also has mispred_o = 1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: no counter registers are built; both outputs are tied to 0. All ports exist in both builds.

## Test plan
- After reset, lookup at 0x0000_0040 -> pred_hit_o = 0, pred_taken_o = 0, pred_target_o = 0x44.
- Update pc 0x40, taken, target 0x100 -> next cycle, lookup 0x40 gives hit = 1, taken = 1, target = 0x100. Lookup 0x80 (ENTRIES=16, same index, different tag) gives hit = 0.
- From the allocated state (counter 2), send three not-taken updates -> counter goes 1 then 0 then 0. pred_taken_o = 0 after the first and stays 0. Four taken updates then saturate the counter at 3.
- Same-cycle lookup and taken update of a new pc 0x200 -> hit = 0 in that cycle, hit = 1 in the next.
- inv_all_i together with an update to 0x40 -> next cycle, lookup 0x40 gives hit = 0 and the update is lost. The same sequence with rst_i pulsed mid-cycle clears the table asynchronously.
- With BP_STATS_EN defined: 5 updates, 2 of them with upd_pred_taken_i != upd_taken_i -> upd_cnt_o = 5, mispred_cnt_o = 2. Undefined -> both outputs stay 0.
